// File: rtl/divider_load_ramp_pkg.sv
// Shared definitions for the divider control blocks: ramp FSM encoding,
// default widths and the default (slowest-clock) load constant.
package divider_load_ramp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_DWELL = 2'd2
    } ramp_state_t;

    localparam int DEF_LOAD_WIDTH  = 24;
    localparam int DEF_STEP_WIDTH  = 16;
    localparam int DEF_DWELL_WIDTH = 16;

    localparam logic [DEF_LOAD_WIDTH-1:0] DEF_RESET_LOAD = '1;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/divider_load_step.sv
// Purpose: one saturating step of the load value toward the target.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module divider_load_step
    import divider_load_ramp_pkg::*;
#(
    parameter int WIDTH      = DEF_LOAD_WIDTH,
    parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
    input  logic [WIDTH-1:0]      cur,
    input  logic [WIDTH-1:0]      target,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [WIDTH-1:0]      next,
    output logic                  reached
);

    // One extra bit so the distance and step compare without wrap.
    localparam int CW = max_width(WIDTH, STEP_WIDTH) + 1;

    logic          up;
    logic [CW-1:0] cur_c;
    logic [CW-1:0] tgt_c;
    logic [CW-1:0] step_c;
    logic [CW-1:0] diff_c;

    always_comb begin
        cur_c   = CW'(cur);
        tgt_c   = CW'(target);
        step_c  = CW'(step);
        up      = (tgt_c > cur_c);
        diff_c  = up ? (tgt_c - cur_c) : (cur_c - tgt_c);
        reached = (step_c == '0) || (diff_c <= step_c);
        next    = target;
        // Not reached implies step < distance, so it fits in WIDTH and cannot overshoot.
        if (!reached) begin
            next = up ? (cur + step_c[WIDTH-1:0]) : (cur - step_c[WIDTH-1:0]);
        end
    end

endmodule

// File: rtl/divider_load_ramp.sv
// Purpose: ramps the divider load value toward a commanded target in bounded, dwelled steps.
// Latency: accept -> first update 1 cycle; each intermediate value held dwell+2 cycles.
// Backpressure: cmd_ready only in IDLE; commands offered while busy wait, nothing is queued.
module divider_load_ramp
    import divider_load_ramp_pkg::*;
#(
    parameter int               WIDTH       = DEF_LOAD_WIDTH,
    parameter int               STEP_WIDTH  = DEF_STEP_WIDTH,
    parameter int               DWELL_WIDTH = DEF_DWELL_WIDTH,
    parameter logic [WIDTH-1:0] RESET_LOAD  = {WIDTH{1'b1}}
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_target,
    input  logic [STEP_WIDTH-1:0]  cmd_step,
    input  logic [DWELL_WIDTH-1:0] cmd_dwell,
    input  logic                   abort,
    output logic [WIDTH-1:0]       load,
    output logic                   busy,
    output logic                   done
);

    ramp_state_t            state;
    logic [WIDTH-1:0]       target_q;
    logic [STEP_WIDTH-1:0]  step_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt;

    logic [WIDTH-1:0]       step_next;
    logic                   step_reached;

    divider_load_step #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step (
        .cur     (load),
        .target  (target_q),
        .step    (step_q),
        .next    (step_next),
        .reached (step_reached)
    );

    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            load      <= RESET_LOAD;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
            target_q  <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        step_q   <= cmd_step;
                        dwell_q  <= cmd_dwell;
                        state    <= ST_STEP;
                        busy     <= 1'b1;
                    end
                end
                ST_STEP: begin
                    // Abort beats the final write: load stays frozen and no done.
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (step_reached) begin
                        load  <= step_next;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        load      <= step_next;
                        dwell_cnt <= dwell_q;
                        state     <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt == '0) begin
                        state <= ST_STEP;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_load_ramp.sv
// Bench for divider_load_ramp: table of ramp commands checked cycle by cycle
// against a trajectory scoreboard, plus abort, handshake, reset and 8-bit boundary sequences.
module tb_divider_load_ramp;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_target = '0;
    logic [15:0] cmd_step = '0;
    logic [15:0] cmd_dwell = '0;
    logic        abort = 1'b0;
    logic [23:0] load;
    logic        busy;
    logic        done;

    logic        c8_valid = 1'b0;
    logic        c8_ready;
    logic [7:0]  c8_target = '0;
    logic [7:0]  c8_step = '0;
    logic [3:0]  c8_dwell = '0;
    logic        c8_abort = 1'b0;
    logic [7:0]  c8_load;
    logic        c8_busy;
    logic        c8_done;

    always #5 clk_in = ~clk_in;

    divider_load_ramp u_dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_dwell  (cmd_dwell),
        .abort      (abort),
        .load       (load),
        .busy       (busy),
        .done       (done)
    );

    divider_load_ramp #(
        .WIDTH       (8),
        .STEP_WIDTH  (8),
        .DWELL_WIDTH (4),
        .RESET_LOAD  (8'hFF)
    ) u_dut8 (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .cmd_valid  (c8_valid),
        .cmd_ready  (c8_ready),
        .cmd_target (c8_target),
        .cmd_step   (c8_step),
        .cmd_dwell  (c8_dwell),
        .abort      (c8_abort),
        .load       (c8_load),
        .busy       (c8_busy),
        .done       (c8_done)
    );

    typedef struct {
        logic [23:0] load;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        logic [23:0] target;
        logic [15:0] step;
        logic [15:0] dwell;
        logic [23:0] exp_final;
    } vec_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_load;
    bit          drop_valid_on_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input logic [23:0] v, input logic b, input logic d);
        exp_t e;
        e.load = v;
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endfunction

    // Reference trajectory in signed 64-bit arithmetic, one entry per cycle after the accept edge.
    function automatic void push_traj(input logic [23:0] cur, input logic [23:0] tgt,
                                      input logic [15:0] step, input logic [15:0] dwell,
                                      input bit trailing);
        longint vi = longint'(cur);
        longint ti = longint'(tgt);
        longint si = longint'(step);
        push_exp(cur, 1'b1, 1'b0);
        while (si != 0 && ((ti > vi) ? (ti - vi) : (vi - ti)) > si) begin
            vi = (ti > vi) ? (vi + si) : (vi - si);
            for (int k = 0; k < int'(dwell) + 2; k++) push_exp(vi[23:0], 1'b1, 1'b0);
        end
        push_exp(tgt, 1'b0, 1'b1);
        if (trailing) push_exp(tgt, 1'b0, 1'b0);
    endfunction

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            @(negedge clk_in);
            e = exp_q.pop_front();
            check({tag, " load"}, 32'(load), 32'(e.load));
            check({tag, " busy"}, 32'(busy), 32'(e.busy));
            check({tag, " done"}, 32'(done), 32'(e.done));
            check({tag, " cmd_ready"}, 32'(cmd_ready), 32'(!e.busy));
            if (e.done && drop_valid_on_done) begin
                @(posedge clk_in);
                #1 cmd_valid = 1'b0;
                drop_valid_on_done = 0;
            end
        end
    endtask

    task automatic send(input logic [23:0] tgt, input logic [15:0] step, input logic [15:0] dwell);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk_in);
            w++;
        end
        check("cmd_ready before send", 32'(cmd_ready), 32'd1);
        cmd_target = tgt;
        cmd_step   = step;
        cmd_dwell  = dwell;
        cmd_valid  = 1'b1;
        @(posedge clk_in);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic cmd8(input logic [7:0] tgt, input logic [7:0] step, input logic [7:0] start,
                        input string name);
        bit got_done = 0;
        bit stray = 0;
        c8_target = tgt;
        c8_step   = step;
        c8_dwell  = 4'd1;
        c8_valid  = 1'b1;
        @(posedge clk_in);
        #1 c8_valid = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge clk_in);
            if (c8_load !== start && c8_load !== tgt) stray = 1;
            if (c8_done === 1'b1) got_done = 1;
        end
        check({name, " done seen"}, 32'(got_done), 32'd1);
        check({name, " stray value"}, 32'(stray), 32'd0);
        check({name, " final load"}, 32'(c8_load), 32'(tgt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   wait_cyc;

        vecs[0] = '{24'd1000,     16'd0,      16'd0, 24'd1000};
        vecs[1] = '{24'd700,      16'd100,    16'd2, 24'd700};
        vecs[2] = '{24'd1000,     16'd250,    16'd0, 24'd1000};
        vecs[3] = '{24'd42,       16'd0,      16'd3, 24'd42};
        vecs[4] = '{24'd42,       16'd5,      16'd1, 24'd42};
        vecs[5] = '{24'hFF0000,   16'd0,      16'd0, 24'hFF0000};
        vecs[6] = '{24'hFFFFFF,   16'h8000,   16'd1, 24'hFFFFFF};
        vecs[7] = '{24'hFFC000,   16'h3000,   16'd0, 24'hFFC000};
        vecs[8] = '{24'd5,        16'd0,      16'd0, 24'd5};
        vecs[9] = '{24'd0,        16'd16,     16'd0, 24'd0};

        // Asynchronous reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("reset load", 32'(load), 32'hFFFFFF);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset load8", 32'(c8_load), 32'hFF);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("post-reset load", 32'(load), 32'hFFFFFF);
        exp_load = 24'hFFFFFF;

        for (int i = 0; i < 10; i++) begin
            push_traj(exp_load, vecs[i].target, vecs[i].step, vecs[i].dwell, 1'b1);
            send(vecs[i].target, vecs[i].step, vecs[i].dwell);
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d final", i), 32'(load), 32'(vecs[i].exp_final));
            exp_load = vecs[i].exp_final;
        end

        // cmd_valid held through a ramp: the second command waits for cmd_ready
        push_traj(exp_load, 24'd30, 16'd10, 16'd1, 1'b0);
        push_traj(24'd30, 24'd999, 16'd0, 16'd0, 1'b1);
        cmd_target = 24'd30;
        cmd_step   = 16'd10;
        cmd_dwell  = 16'd1;
        cmd_valid  = 1'b1;
        @(posedge clk_in);
        #1;
        cmd_target = 24'd999;
        cmd_step   = 16'd0;
        cmd_dwell  = 16'd0;
        drop_valid_on_done = 1;
        drain("held valid");
        exp_load = 24'd999;

        push_traj(exp_load, 24'd0, 16'd0, 16'd0, 1'b1);
        send(24'd0, 16'd0, 16'd0);
        drain("to zero");
        exp_load = 24'd0;

        // Abort during DWELL at load 50
        send(24'd1000, 16'd10, 16'd5);
        wait_cyc = 0;
        while (load !== 24'd50 && wait_cyc < 100) begin
            @(negedge clk_in);
            wait_cyc++;
        end
        check("abort reach-50 cycles", 32'(wait_cyc), 32'd30);
        check("abort busy before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk_in);
        #1 abort = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            check("abort frozen load", 32'(load), 32'd50);
            check("abort no done", 32'(done), 32'd0);
            check("abort idle", 32'(busy), 32'd0);
        end

        // Abort in the STEP cycle that would reach the target
        send(24'd55, 16'd0, 16'd0);
        abort = 1'b1;
        @(posedge clk_in);
        #1 abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("step-abort load", 32'(load), 32'd50);
            check("step-abort no done", 32'(done), 32'd0);
            check("step-abort idle", 32'(busy), 32'd0);
        end
        exp_load = 24'd50;

        // Abort in IDLE must not block a simultaneous accept
        abort = 1'b1;
        push_traj(exp_load, 24'd60, 16'd0, 16'd0, 1'b1);
        send(24'd60, 16'd0, 16'd0);
        abort = 1'b0;
        drain("idle abort");
        exp_load = 24'd60;

        // Reset in the middle of a ramp
        send(24'd1000, 16'd10, 16'd0);
        repeat (5) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        check("midramp reset load", 32'(load), 32'hFFFFFF);
        check("midramp reset busy", 32'(busy), 32'd0);
        check("midramp reset done", 32'(done), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        check("midramp release cmd_ready", 32'(cmd_ready), 32'd1);
        check("midramp release load", 32'(load), 32'hFFFFFF);
        check("midramp release busy", 32'(busy), 32'd0);

        // 8-bit boundaries: no wrap below zero or above all-ones
        cmd8(8'd5,   8'd0,  8'hFF,  "w8 jump5");
        cmd8(8'd0,   8'd16, 8'd5,   "w8 floor");
        cmd8(8'd250, 8'd0,  8'd0,   "w8 jump250");
        cmd8(8'd255, 8'd16, 8'd250, "w8 ceiling");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
